// File: rtl/apb_arb_pkg.sv
// Shared types and defaults for the arbitrated APB master.
// Latency: n/a (package).
// Backpressure: n/a (package).
// Contents: FSM state enum, default parameter values, latched APB command struct.
package apb_arb_pkg;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_TIMEOUT = 16;

    // APB caps PADDR and PWDATA at 32 bits, so the latched command is sized
    // for the widest legal bus; narrower instances zero-extend into it.
    localparam int CMD_ADDR_W = 32;
    localparam int CMD_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_t;

    typedef struct packed {
        logic                  write;
        logic [CMD_ADDR_W-1:0] addr;
        logic [CMD_DATA_W-1:0] wdata;
    } apb_cmd_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin requester selection, search starting one past last_grant.
// Latency: combinational.
// Backpressure: none; the caller decides when a grant is taken.
// Ports: req (pending vector), last_grant (index) in; grant (one-hot),
//        grant_idx (index), grant_vld (any request) out.
module rr_arbiter
    import apb_arb_pkg::*;
#(
    parameter  int NUM_REQ = DEF_NUM_REQ,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_vld
);

    // One extra bit so last_grant + k (at most 2*NUM_REQ-1) never overflows
    // before the wrap subtraction.
    logic [IDX_W:0] cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = {1'b0, last_grant} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(NUM_REQ)) begin
                cand = cand - (IDX_W+1)'(NUM_REQ);
            end
            if (!grant_vld && req[cand[IDX_W-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = cand[IDX_W-1:0];
            end
        end
        grant[grant_idx] = grant_vld;
    end

endmodule

// File: rtl/apb_arb_master.sv
// APB master shared by NUM_REQ requesters through a round-robin arbiter.
// Latency: grant -> SETUP next cycle, ACCESS after that, response the cycle after pready/timeout.
// Backpressure: requesters hold req_valid_i until req_ready_o; slave stalls via pready_i, capped at TIMEOUT.
// Ports: req_* command inputs per requester, req_ready_o accept pulse, rsp_* completion pulse
//        to the owner, APB master signals p*_o / slave response p*_i.
module apb_arb_master
    import apb_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                           pclk,
    input  logic                           preset_n,
    input  logic [NUM_REQ-1:0]             req_valid_i,
    input  logic [NUM_REQ-1:0]             req_write_i,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr_i,
    input  logic [NUM_REQ-1:0][DATA_W-1:0] req_wdata_i,
    output logic [NUM_REQ-1:0]             req_ready_o,
    output logic [NUM_REQ-1:0]             rsp_valid_o,
    output logic [DATA_W-1:0]              rsp_rdata_o,
    output logic                           rsp_err_o,
    output logic                           psel_o,
    output logic                           penable_o,
    output logic                           pwrite_o,
    output logic [ADDR_W-1:0]              paddr_o,
    output logic [DATA_W-1:0]              pwdata_o,
    input  logic [DATA_W-1:0]              prdata_i,
    input  logic                           pready_i,
    input  logic                           pslverr_i
);

    localparam int IDX_W = $clog2(NUM_REQ);

    apb_state_t         state_q;
    apb_cmd_t           cmd_q;
    // Doubles as the owner of the transfer in flight: it only moves on grant.
    logic [IDX_W-1:0]   last_grant_q;
    logic [7:0]         wait_cnt_q;

    logic [NUM_REQ-1:0] arb_grant;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_vld;

    rr_arbiter #(
        .NUM_REQ    (NUM_REQ)
    ) u_rr_arbiter (
        .req        (req_valid_i),
        .last_grant (last_grant_q),
        .grant      (arb_grant),
        .grant_idx  (arb_idx),
        .grant_vld  (arb_vld)
    );

    // The latched command register is the APB address/data/direction source,
    // so these stay stable from SETUP through the end of ACCESS.
    assign pwrite_o = cmd_q.write;
    assign paddr_o  = cmd_q.addr[ADDR_W-1:0];
    assign pwdata_o = cmd_q.wdata[DATA_W-1:0];

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state_q      <= ST_IDLE;
            cmd_q        <= '0;
            last_grant_q <= IDX_W'(NUM_REQ-1);
            wait_cnt_q   <= '0;
            psel_o       <= 1'b0;
            penable_o    <= 1'b0;
            req_ready_o  <= '0;
            rsp_valid_o  <= '0;
            rsp_rdata_o  <= '0;
            rsp_err_o    <= 1'b0;
        end else begin
            // Handshake and response outputs are single-cycle pulses.
            req_ready_o <= '0;
            rsp_valid_o <= '0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    psel_o    <= 1'b0;
                    penable_o <= 1'b0;
                    if (arb_vld) begin
                        state_q      <= ST_SETUP;
                        last_grant_q <= arb_idx;
                        req_ready_o  <= arb_grant;
                        cmd_q.write  <= req_write_i[arb_idx];
                        cmd_q.addr   <= CMD_ADDR_W'(req_addr_i[arb_idx]);
                        cmd_q.wdata  <= CMD_DATA_W'(req_wdata_i[arb_idx]);
                        psel_o       <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    penable_o  <= 1'b1;
                    wait_cnt_q <= '0;
                    state_q    <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (pready_i) begin
                        state_q     <= ST_IDLE;
                        psel_o      <= 1'b0;
                        penable_o   <= 1'b0;
                        rsp_valid_o <= NUM_REQ'(1) << last_grant_q;
                        rsp_rdata_o <= cmd_q.write ? '0 : prdata_i;
                        rsp_err_o   <= pslverr_i;
                    end else if (wait_cnt_q == 8'(TIMEOUT-1)) begin
                        // This is the TIMEOUT-th stalled ACCESS cycle: give up.
                        state_q     <= ST_IDLE;
                        psel_o      <= 1'b0;
                        penable_o   <= 1'b0;
                        rsp_valid_o <= NUM_REQ'(1) << last_grant_q;
                        rsp_err_o   <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    psel_o    <= 1'b0;
                    penable_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_arb_master.sv
// Self-checking bench for apb_arb_master: transaction-level timeline model plus directed literal checks.
// Latency: n/a (testbench).
// Backpressure: bench requesters hold commands until accepted; bench slave stalls per transaction.
module tb_apb_arb_master;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    logic                   pclk     = 1'b0;
    logic                   preset_n = 1'b1;
    logic [N-1:0]           req_valid_i;
    logic [N-1:0]           req_write_i;
    logic [N-1:0][AW-1:0]   req_addr_i;
    logic [N-1:0][DW-1:0]   req_wdata_i;
    logic [N-1:0]           req_ready_o;
    logic [N-1:0]           rsp_valid_o;
    logic [DW-1:0]          rsp_rdata_o;
    logic                   rsp_err_o;
    logic                   psel_o;
    logic                   penable_o;
    logic                   pwrite_o;
    logic [AW-1:0]          paddr_o;
    logic [DW-1:0]          pwdata_o;
    logic [DW-1:0]          prdata_i;
    logic                   pready_i;
    logic                   pslverr_i;

    apb_arb_master #(
        .NUM_REQ (N),
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (TO)
    ) dut (
        .pclk        (pclk),
        .preset_n    (preset_n),
        .req_valid_i (req_valid_i),
        .req_write_i (req_write_i),
        .req_addr_i  (req_addr_i),
        .req_wdata_i (req_wdata_i),
        .req_ready_o (req_ready_o),
        .rsp_valid_o (rsp_valid_o),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_err_o   (rsp_err_o),
        .psel_o      (psel_o),
        .penable_o   (penable_o),
        .pwrite_o    (pwrite_o),
        .paddr_o     (paddr_o),
        .pwdata_o    (pwdata_o),
        .prdata_i    (prdata_i),
        .pready_i    (pready_i),
        .pslverr_i   (pslverr_i)
    );

    always #5 pclk = ~pclk;

    int n_checks = 0;
    int n_fail   = 0;

    // Requester-side view: pending command per requester.
    bit            m_vld   [N];
    bit            m_wr    [N];
    logic [AW-1:0] m_addr  [N];
    logic [DW-1:0] m_wdata [N];

    // Transfer timeline: ph is the cycle index since the grant edge
    // (0 = no transfer; 1 = setup; 2..t_len+1 = access; t_len+2 = response).
    int            last_g;
    int            ph;
    int            own;
    int            t_w;
    int            t_len;
    bit            t_wr;
    bit            t_err;
    logic [AW-1:0] t_addr;
    logic [DW-1:0] t_wdata;
    logic [DW-1:0] t_rdata;

    // Slave drive for the current cycle.
    bit            s_rdy;
    bit            s_err;
    logic [DW-1:0] s_rdata;

    // Stimulus knobs.
    int            force_w   = -1;
    int            force_err = -1;
    bit            use_frd   = 1'b0;
    logic [DW-1:0] frd       = '0;
    int            renew_pct = 0;
    int            gen_pct   = 0;
    int            drop_pct  = 0;

    // Captured response from wait_rsp.
    int            cap_acc;
    bit            cap_seen;
    logic [N-1:0]  cap_rsp;
    logic          cap_err;
    logic [DW-1:0] cap_rdata;
    logic          cap_psel;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit pct(input int p);
        return int'($urandom_range(0, 99)) < p;
    endfunction

    task automatic apply();
        for (int i = 0; i < N; i++) begin
            req_valid_i[i] = m_vld[i];
            req_write_i[i] = m_wr[i];
            req_addr_i[i]  = m_addr[i];
            req_wdata_i[i] = m_wdata[i];
        end
        pready_i  = s_rdy;
        pslverr_i = s_err;
        prdata_i  = s_rdata;
    endtask

    task automatic new_cmd(input int i);
        m_vld[i]   = 1'b1;
        m_wr[i]    = 1'($urandom_range(0, 1));
        m_addr[i]  = $urandom;
        m_wdata[i] = $urandom;
    endtask

    task automatic issue(input int i, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        m_vld[i]   = 1'b1;
        m_wr[i]    = wr;
        m_addr[i]  = a;
        m_wdata[i] = d;
        apply();
    endtask

    // Decide what the coming clock edge does, from the inputs now on the pins.
    task automatic compute_next();
        int pick;
        int r;
        if (ph >= 2 && ph == t_len + 1) begin
            if (t_w < TO) begin
                t_err   = s_err;
                t_rdata = t_wr ? '0 : s_rdata;
            end else begin
                t_err   = 1'b1;
                t_rdata = '0;
            end
        end
        if (ph != 0 && ph != t_len + 2) begin
            ph++;
            return;
        end
        pick = -1;
        for (int k = 1; k <= N; k++) begin
            if (pick < 0 && m_vld[(last_g + k) % N]) pick = (last_g + k) % N;
        end
        if (pick < 0) begin
            ph = 0;
            return;
        end
        own     = pick;
        last_g  = pick;
        t_wr    = m_wr[pick];
        t_addr  = m_addr[pick];
        t_wdata = m_wdata[pick];
        if (force_w >= 0) begin
            t_w = force_w;
        end else begin
            r   = int'($urandom_range(0, 19));
            t_w = (r == 19) ? 100 : (r == 18) ? TO - 1 : r % 6;
        end
        t_len = (t_w < TO) ? t_w + 1 : TO;
        ph    = 1;
    endtask

    task automatic compare();
        logic [N-1:0] e_ready;
        logic [N-1:0] e_rsp;
        bit           e_psel;
        bit           e_pen;
        e_ready = '0;
        e_rsp   = '0;
        if (ph == 1) e_ready[own] = 1'b1;
        if (ph != 0 && ph == t_len + 2) e_rsp[own] = 1'b1;
        e_psel = (ph >= 1 && ph <= t_len + 1);
        e_pen  = (ph >= 2 && ph <= t_len + 1);
        chk("req_ready", req_ready_o, e_ready);
        chk("rsp_valid", rsp_valid_o, e_rsp);
        chk("psel", psel_o, e_psel);
        chk("penable", penable_o, e_pen);
        if (e_psel) begin
            chk("paddr", paddr_o, t_addr);
            chk("pwrite", pwrite_o, t_wr);
            chk("pwdata", pwdata_o, t_wdata);
        end
        if (e_rsp != '0) begin
            chk("rsp_err", rsp_err_o, t_err);
            chk("rsp_rdata", rsp_rdata_o, t_rdata);
        end
    endtask

    task automatic react();
        for (int i = 0; i < N; i++) begin
            if (ph == 1 && own == i) begin
                if (pct(renew_pct)) new_cmd(i);
                else m_vld[i] = 1'b0;
            end else if (m_vld[i]) begin
                if (pct(drop_pct)) m_vld[i] = 1'b0;
            end else if (pct(gen_pct)) begin
                new_cmd(i);
            end
        end
        if (ph >= 2 && ph <= t_len + 1) begin
            s_rdy   = (t_w < TO) && (ph - 2 == t_w);
            s_err   = (force_err >= 0) ? force_err[0] : ($urandom_range(0, 3) == 0);
            s_rdata = use_frd ? frd : $urandom;
        end else begin
            // Noise outside ACCESS; the master must ignore it.
            s_rdy   = 1'($urandom_range(0, 1));
            s_err   = 1'($urandom_range(0, 1));
            s_rdata = $urandom;
        end
        apply();
    endtask

    task automatic step();
        compute_next();
        @(posedge pclk);
        #1;
        compare();
        react();
    endtask

    task automatic do_reset();
        preset_n = 1'b0;
        ph       = 0;
        last_g   = N - 1;
        #1;
        chk("rst_psel", psel_o, 0);
        chk("rst_penable", penable_o, 0);
        chk("rst_req_ready", req_ready_o, 0);
        chk("rst_rsp_valid", rsp_valid_o, 0);
        chk("rst_rsp_err", rsp_err_o, 0);
        chk("rst_rsp_rdata", rsp_rdata_o, 0);
        repeat (2) begin
            @(posedge pclk);
            #1;
            chk("rst_hold_rsp_valid", rsp_valid_o, 0);
            chk("rst_hold_psel", psel_o, 0);
        end
        @(negedge pclk);
        preset_n = 1'b1;
    endtask

    task automatic wait_rsp(input int limit, input bit chk_stable,
                            input logic [AW-1:0] lit_addr, input logic [DW-1:0] lit_wdata);
        cap_acc  = 0;
        cap_seen = 1'b0;
        for (int c = 0; c < limit && !cap_seen; c++) begin
            step();
            if (psel_o && penable_o) begin
                cap_acc++;
                if (chk_stable) begin
                    chk("ws_paddr", paddr_o, lit_addr);
                    chk("ws_pwdata", pwdata_o, lit_wdata);
                end
            end
            if (rsp_valid_o != '0) begin
                cap_seen  = 1'b1;
                cap_rsp   = rsp_valid_o;
                cap_err   = rsp_err_o;
                cap_rdata = rsp_rdata_o;
                cap_psel  = psel_o;
            end
        end
        chk("rsp_seen", cap_seen, 1);
    endtask

    task automatic run_idle(input int limit);
        bit busy;
        busy = 1'b1;
        for (int c = 0; c < limit && busy; c++) begin
            step();
            busy = (ph != 0);
            for (int i = 0; i < N; i++) if (m_vld[i]) busy = 1'b1;
        end
        chk("drain", busy, 0);
    endtask

    function automatic int oh2idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    initial begin
        int q[$];
        int exp_order[5] = '{0, 1, 2, 3, 0};

        for (int i = 0; i < N; i++) begin
            m_vld[i]   = 1'b0;
            m_wr[i]    = 1'b0;
            m_addr[i]  = '0;
            m_wdata[i] = '0;
        end
        s_rdy = 1'b0; s_err = 1'b0; s_rdata = '0;
        ph = 0; last_g = N - 1; own = 0; t_len = 1; t_w = 0;
        apply();
        #2;
        do_reset();

        // Single read, zero wait states.
        force_w = 0; force_err = 0; use_frd = 1'b1; frd = 32'h0000_00A5;
        issue(0, 1'b0, 32'h0000_0010, 32'h0);
        step();
        chk("rd_ready", req_ready_o, 4'b0001);
        chk("rd_setup_psel", psel_o, 1);
        chk("rd_setup_penable", penable_o, 0);
        chk("rd_setup_paddr", paddr_o, 32'h10);
        step();
        chk("rd_access_penable", penable_o, 1);
        step();
        chk("rd_rsp_valid", rsp_valid_o, 4'b0001);
        chk("rd_rsp_rdata", rsp_rdata_o, 32'hA5);
        chk("rd_rsp_err", rsp_err_o, 0);
        chk("rd_rsp_psel", psel_o, 0);
        use_frd = 1'b0;

        // Fairness: everyone always pending from reset.
        do_reset();
        renew_pct = 100;
        for (int i = 0; i < N; i++) new_cmd(i);
        apply();
        for (int c = 0; c < 15; c++) begin
            step();
            if (req_ready_o != '0) q.push_back(oh2idx(req_ready_o));
        end
        chk("fair_cnt", q.size() >= 5, 1);
        for (int i = 0; i < 5 && i < q.size(); i++) chk($sformatf("fair_order%0d", i), q[i], exp_order[i]);
        renew_pct = 0;
        run_idle(100);

        // Write with three wait states.
        force_w = 3;
        issue(1, 1'b1, 32'h2000_0040, 32'hDEAD_BEEF);
        wait_rsp(20, 1'b1, 32'h2000_0040, 32'hDEAD_BEEF);
        chk("ws_access_cycles", cap_acc, 4);
        chk("ws_rsp_valid", cap_rsp, 4'b0010);
        chk("ws_rsp_err", cap_err, 0);

        // Timeout: slave never ready.
        force_w = 100;
        issue(3, 1'b0, 32'h0000_0030, 32'h0);
        wait_rsp(40, 1'b0, '0, '0);
        chk("to_access_cycles", cap_acc, 16);
        chk("to_rsp_valid", cap_rsp, 4'b1000);
        chk("to_rsp_err", cap_err, 1);
        chk("to_rsp_rdata", cap_rdata, 0);
        chk("to_psel", cap_psel, 0);

        // Slave error goes to the owner only.
        force_w = 0; force_err = 1;
        issue(2, 1'b0, 32'h0000_0044, 32'h0);
        wait_rsp(10, 1'b0, '0, '0);
        chk("se_rsp_valid", cap_rsp, 4'b0100);
        chk("se_rsp_err", cap_err, 1);
        force_err = -1;

        // Randomized traffic.
        force_w = -1; gen_pct = 30; drop_pct = 5; renew_pct = 40;
        for (int c = 0; c < 3000; c++) step();
        gen_pct = 0; drop_pct = 0; renew_pct = 0;
        run_idle(300);

        // Reset in the middle of ACCESS.
        do_reset();
        force_w = 10;
        issue(0, 1'b0, 32'h0000_0100, 32'h0);
        issue(2, 1'b1, 32'h0000_0200, 32'h1234_5678);
        repeat (3) step();
        chk("mr_in_access", psel_o && penable_o, 1);
        #2;
        do_reset();
        force_w = 0;
        step();
        chk("mr_regrant", req_ready_o, 4'b0100);
        run_idle(40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_arb_master.md
APB_ARB_MASTER -- requirements
Module: apb_arb_master

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing the APB master port (range 2..8).
REQ-002 Parameter ADDR_W, default 32: APB address width.
REQ-003 Parameter DATA_W, default 32: APB data width.
REQ-004 Parameter TIMEOUT, default 16: maximum ACCESS cycles without pready_i before forced abort (range 2..255).
REQ-005 pclk  in  1  APB clock; all logic on rising edge.
REQ-006 preset_n  in  1  reset, asynchronous, active-low.
REQ-007 req_valid_i  in  NUM_REQ  per-requester command pending; held until req_ready_o for that requester.
REQ-008 req_write_i  in  NUM_REQ  per-requester direction (1 write, 0 read).
REQ-009 req_addr_i  in  NUM_REQ x ADDR_W  per-requester address.
REQ-010 req_wdata_i  in  NUM_REQ x DATA_W  per-requester write data.
REQ-011 req_ready_o  out  NUM_REQ  one-hot, one-cycle command-accepted pulse.
REQ-012 rsp_valid_o  out  NUM_REQ  one-hot, one-cycle completion pulse to the owning requester.
REQ-013 rsp_rdata_o  out  DATA_W  read data; valid while any rsp_valid_o is high.
REQ-014 rsp_err_o  out  1  completion error (pslverr_i or timeout); valid with rsp_valid_o.
REQ-015 psel_o, penable_o, pwrite_o  out  1 each  APB control.
REQ-016 paddr_o  out  ADDR_W; pwdata_o  out  DATA_W  APB address/write data.
REQ-017 prdata_i  in  DATA_W; pready_i  in  1; pslverr_i  in  1  APB slave response.

Function
REQ-018 FSM states IDLE, SETUP, ACCESS; all APB and response outputs registered.
REQ-019 IDLE: if any req_valid_i set, grant one requester by round-robin (search starts at last_grant+1, wrapping NUM_REQ-1 -> 0), latch its write/addr/wdata, pulse req_ready_o[grant], go SETUP.
REQ-020 IDLE with no req_valid_i: stay IDLE; psel_o=0, penable_o=0.
REQ-021 SETUP: psel_o=1, penable_o=0, paddr_o/pwrite_o/pwdata_o = latched command; unconditional transition to ACCESS.
REQ-022 ACCESS: psel_o=1, penable_o=1, address/control/data held stable; wait-cycle counter increments each cycle pready_i=0.
REQ-023 ACCESS with pready_i=1: capture prdata_i (reads only; writes return 0) and pslverr_i; next cycle IDLE with rsp_valid_o[grant]=1.
REQ-024 ACCESS with counter reaching TIMEOUT and pready_i=0: abort; next cycle IDLE, psel_o=0, rsp_valid_o[grant]=1, rsp_err_o=1, rsp_rdata_o=0.
REQ-025 Response pulse cycle is an IDLE cycle; a new grant may occur in that same cycle (zero-wait throughput: one transfer per 3 cycles).
REQ-026 last_grant updates only on grant; simultaneous requests never starve (each waits at most NUM_REQ-1 transfers).
REQ-027 Requester deasserting req_valid_i before grant: no transfer, no response for it.
REQ-028 pready_i/pslverr_i ignored outside ACCESS.

Reset
REQ-029 On preset_n low: state IDLE, last_grant=NUM_REQ-1 (first grant favours requester 0), counter 0, all outputs 0.
REQ-030 Reset mid-transfer: bus released immediately (psel_o=0, penable_o=0); no rsp_valid_o for the aborted transfer.

Structure
REQ-031 Shared package apb_arb_pkg holds FSM state enum, default parameter constants, and APB command struct (write, addr, wdata).
REQ-032 Round-robin grant logic is one sub-module, rr_arbiter (req vector, last_grant in; one-hot grant, index out).

Verification
REQ-033 Single read: req 0 read 0x10, pready_i=1 first ACCESS cycle, prdata_i=0xA5 -> SETUP at T+1, ACCESS T+2, rsp_valid_o[0] with rdata 0xA5, err 0 at T+3.
REQ-034 Fairness: all 4 requesters valid from reset -> grant order 0,1,2,3,0; each granted once per 4 transfers.
REQ-035 Wait states: write, pready_i low 3 ACCESS cycles -> paddr_o/pwdata_o/psel_o/penable_o stable all 4 ACCESS cycles; rsp_err_o=0.
REQ-036 Timeout: TIMEOUT=16, pready_i never high -> abort after 16 ACCESS cycles, rsp_err_o=1, rsp_rdata_o=0, psel_o low next cycle.
REQ-037 Slave error: pslverr_i=1 with pready_i=1 -> rsp_err_o=1 to owner only.
REQ-038 Reset in ACCESS: preset_n low -> psel_o/penable_o 0 asynchronously; no rsp_valid_o; after release, first pending request granted normally.
